ball_datapath: RTL

BALL_DATAPATH -- requirements
Module: ball_datapath

---
 rtl/ball_datapath_if.sv | 30 +++
 rtl/ball_datapath.sv | 99 +++++++++
 2 files changed

// File: rtl/ball_datapath_if.sv
// Control/status bundle between the ball controller and ball_datapath,
// together with the VGA pixel write port the datapath drives.
interface ball_datapath_if;
    logic       plot;
    logic       ld_x_out;
    logic       ld_y_out;
    logic       enable_posCounter_W;
    logic       enable_posCounter_B;
    logic       enable_delayCounter;
    logic       sel_col;
    logic       doneW;
    logic       doneB;
    logic       waited;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       writeEn;

    modport master (
        output plot, ld_x_out, ld_y_out, enable_posCounter_W, enable_posCounter_B,
               enable_delayCounter, sel_col,
        input  doneW, doneB, waited, x_out, y_out, colour, writeEn
    );

    modport slave (
        input  plot, ld_x_out, ld_y_out, enable_posCounter_W, enable_posCounter_B,
               enable_delayCounter, sel_col,
        output doneW, doneB, waited, x_out, y_out, colour, writeEn
    );
endinterface

// File: rtl/ball_datapath.sv
// Bouncing 4x4 ball datapath: position/direction registers, pixel sweep
// counter for draw/erase passes, and a frame-delay counter.
module ball_datapath #(
    parameter logic [7:0]  START_X      = 8'd78,
    parameter logic [6:0]  START_Y      = 7'd58,
    parameter logic [19:0] DELAY_CYCLES = 20'd833333,
    parameter logic [2:0]  BALL_COLOUR  = 3'b111
) (
    input  logic           clock,
    input  logic           reset,
    ball_datapath_if.slave bus
);
    localparam logic [7:0] X_MAX = 8'd156;
    localparam logic [6:0] Y_MAX = 7'd116;

    logic [7:0]  ballX_q, ballX_d;
    logic [6:0]  ballY_q, ballY_d;
    logic        dirX_q, dirX_d;
    logic        dirY_q, dirY_d;
    logic [3:0]  pixCnt_q, pixCnt_d;
    logic [19:0] delayCnt_q, delayCnt_d;
    logic        lastPix, drawDone, eraseDone, delayDone, pixEn;

    always_comb begin
        pixEn     = bus.enable_posCounter_W || bus.enable_posCounter_B;
        lastPix   = (pixCnt_q == 4'd15);
        drawDone  = bus.enable_posCounter_W && lastPix;
        eraseDone = bus.enable_posCounter_B && !bus.enable_posCounter_W && lastPix;
        delayDone = bus.enable_delayCounter && (delayCnt_q == DELAY_CYCLES - 20'd1);

        pixCnt_d   = pixEn ? pixCnt_q + 4'd1 : 4'd0;
        delayCnt_d = (bus.enable_delayCounter && !delayDone) ? delayCnt_q + 20'd1 : 20'd0;

        ballX_d = ballX_q;
        dirX_d  = dirX_q;
        ballY_d = ballY_q;
        dirY_d  = dirY_q;

        // The ball only moves at the end of an erase pass, so the next draw
        // lands on the new position; a load always wins over that step.
        if (bus.ld_x_out) begin
            ballX_d = START_X;
            dirX_d  = 1'b1;
        end else if (eraseDone) begin
            if (dirX_q && ballX_q == X_MAX) begin
                ballX_d = X_MAX - 8'd1;
                dirX_d  = 1'b0;
            end else if (!dirX_q && ballX_q == 8'd0) begin
                ballX_d = 8'd1;
                dirX_d  = 1'b1;
            end else begin
                ballX_d = dirX_q ? ballX_q + 8'd1 : ballX_q - 8'd1;
            end
        end

        if (bus.ld_y_out) begin
            ballY_d = START_Y;
            dirY_d  = 1'b1;
        end else if (eraseDone) begin
            if (dirY_q && ballY_q == Y_MAX) begin
                ballY_d = Y_MAX - 7'd1;
                dirY_d  = 1'b0;
            end else if (!dirY_q && ballY_q == 7'd0) begin
                ballY_d = 7'd1;
                dirY_d  = 1'b1;
            end else begin
                ballY_d = dirY_q ? ballY_q + 7'd1 : ballY_q - 7'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ballX_q    <= START_X;
            ballY_q    <= START_Y;
            dirX_q     <= 1'b1;
            dirY_q     <= 1'b1;
            pixCnt_q   <= 4'd0;
            delayCnt_q <= 20'd0;
        end else begin
            ballX_q    <= ballX_d;
            ballY_q    <= ballY_d;
            dirX_q     <= dirX_d;
            dirY_q     <= dirY_d;
            pixCnt_q   <= pixCnt_d;
            delayCnt_q <= delayCnt_d;
        end
    end

    // Strobes are suppressed during reset and the start position is shown
    // even before the first reset edge has loaded the registers.
    assign bus.x_out   = reset ? START_X : ballX_q + {6'd0, pixCnt_q[1:0]};
    assign bus.y_out   = reset ? START_Y : ballY_q + {5'd0, pixCnt_q[3:2]};
    assign bus.doneW   = !reset && drawDone;
    assign bus.doneB   = !reset && eraseDone;
    assign bus.waited  = !reset && delayDone;
    assign bus.writeEn = !reset && bus.plot;
    assign bus.colour  = bus.sel_col ? 3'b000 : BALL_COLOUR;
endmodule
